// File: rtl/lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit.
//   lsu_size_e  : access size carried on req_size_i
//   lsu_cause_e : completion cause returned on rsp_cause_o
//   lsu_state_e : control FSM states of wb_lsu
//   lsu_misaligned() : alignment check used at request acceptance
package lsu_pkg;

  typedef enum logic [1:0] {
    SzByte  = 2'd0,
    SzHalf  = 2'd1,
    SzWord  = 2'd2,
    SzDword = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    CauseOk       = 2'd0,
    CauseMisalign = 2'd1,
    CauseBusErr   = 2'd2,
    CauseTimeout  = 2'd3
  } lsu_cause_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size, or when a
  // doubleword is requested on a 32-bit bus (it cannot be carried in one beat).
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [2:0] addr_lo,
                                          input logic       dw64);
    logic mis;
    mis = 1'b0;
    unique case (size)
      SzByte:  mis = 1'b0;
      SzHalf:  mis = addr_lo[0];
      SzWord:  mis = |addr_lo[1:0];
      SzDword: mis = ~dw64 | (|addr_lo);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering and load extension for wb_lsu (purely combinational).
//   size_i   : access size (lsu_size_e encoding)
//   uns_i    : 1 = zero-extend loads, 0 = sign-extend
//   off_i    : byte offset of the access within the bus word
//   wdata_i  : right-justified store data
//   rdata_i  : raw bus read data
//   sel_o    : byte-lane enables for the access
//   wdata_o  : store data moved onto its lanes
//   rdata_o  : load data moved down, truncated to size and extended to DW
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]                size_i,
  input  logic                      uns_i,
  input  logic [$clog2(DW/8)-1:0]   off_i,
  input  logic [DW-1:0]             wdata_i,
  input  logic [DW-1:0]             rdata_i,
  output logic [DW/8-1:0]           sel_o,
  output logic [DW-1:0]             wdata_o,
  output logic [DW-1:0]             rdata_o
);

  localparam int unsigned NB = DW / 8;

  logic [NB-1:0] mask;
  logic [DW-1:0] shifted;

  always_comb begin
    mask = '0;
    unique case (size_i)
      SzByte:  mask = NB'(8'h01);
      SzHalf:  mask = NB'(8'h03);
      SzWord:  mask = NB'(8'h0F);
      SzDword: mask = NB'(8'hFF);
      default: mask = '0;
    endcase
  end

  assign sel_o   = mask << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign shifted = rdata_i >> {off_i, 3'b000};

  // Signed size casts sign-extend, unsigned ones zero-extend.
  always_comb begin
    rdata_o = shifted;
    unique case (size_i)
      SzByte: begin
        if (uns_i) rdata_o = DW'(shifted[7:0]);
        else       rdata_o = DW'($signed(shifted[7:0]));
      end
      SzHalf: begin
        if (uns_i) rdata_o = DW'(shifted[15:0]);
        else       rdata_o = DW'($signed(shifted[15:0]));
      end
      SzWord: begin
        if (uns_i) rdata_o = DW'(shifted[31:0]);
        else       rdata_o = DW'($signed(shifted[31:0]));
      end
      SzDword: rdata_o = shifted;
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/wb_lsu.sv
// Load/store unit bridging a valid/ready core request port to a Wishbone classic master.
// One transaction outstanding: IDLE -> BUS -> RESP, or IDLE -> RESP for misaligned requests.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_*                 : core request (valid/ready handshake, fields latched at accept)
//   rsp_valid_o           : one-cycle completion strobe with rsp_rdata_o / rsp_cause_o
//   wb_adr/dat/sel/we_o   : registered Wishbone address, write data, lanes, direction
//   wb_cyc_o, wb_stb_o    : Wishbone cycle/strobe (identical in classic single beats)
//   wb_dat_i/ack_i/err_i  : Wishbone returns
module wb_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic [1:0]      rsp_cause_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OW   = $clog2(NB);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic        Dw64 = (DW == 64);

  lsu_state_e      state_q, state_d;
  lsu_cause_e      cause_q, cause_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic            cyc_q, cyc_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [OW-1:0]   off_q, off_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0]      lane_size;
  logic [OW-1:0]   lane_off;
  logic [NB-1:0]   lane_sel;
  logic [DW-1:0]   lane_wdata;
  logic [DW-1:0]   lane_rdata;
  logic            accept;
  logic            misaligned;
  logic            timed_out;

  // In IDLE the aligner sees the live request (store steering); afterwards it sees the
  // latched fields so the load path is immune to request-port activity.
  assign lane_size = (state_q == StIdle) ? req_size_i : size_q;
  assign lane_off  = (state_q == StIdle) ? req_addr_i[OW-1:0] : off_q;

  lsu_lane_align #(
    .DW(DW)
  ) u_lane_align (
    .size_i  (lane_size),
    .uns_i   (uns_q),
    .off_i   (lane_off),
    .wdata_i (req_wdata_i),
    .rdata_i (wb_dat_i),
    .sel_o   (lane_sel),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign accept     = req_valid_i && (state_q == StIdle);
  assign misaligned = lsu_misaligned(req_size_i, req_addr_i[2:0], Dw64);
  // Counter starts at 0 on the first BUS cycle, so the limit is hit on cycle TIMEOUT.
  assign timed_out  = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          off_d  = req_addr_i[OW-1:0];
          if (misaligned) begin
            state_d = StResp;
            cause_d = CauseMisalign;
            rdata_d = '0;
          end else begin
            state_d = StBus;
            cyc_d   = 1'b1;
            we_d    = req_we_i;
            adr_d   = req_addr_i & ~AW'(NB - 1);
            sel_d   = lane_sel;
            dat_d   = lane_wdata;
            cnt_d   = '0;
          end
        end
      end

      StBus: begin
        cnt_d = cnt_q + CntW'(1);
        if (wb_err_i) begin
          state_d = StResp;
          cause_d = CauseBusErr;
          rdata_d = '0;
          cyc_d   = 1'b0;
        end else if (wb_ack_i) begin
          state_d = StResp;
          cause_d = CauseOk;
          rdata_d = we_q ? '0 : lane_rdata;
          cyc_d   = 1'b0;
        end else if (timed_out) begin
          state_d = StResp;
          cause_d = CauseTimeout;
          rdata_d = '0;
          cyc_d   = 1'b0;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cause_q <= CauseOk;
      rdata_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_cause_o = cause_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_wb_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v32, v64, we, uns;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [63:0] wdata, bdat;
  logic        ack32, err32, ack64, err64;

  logic        rdy32, rv32, we32, cyc32, stb32;
  logic [31:0] rd32, adr32, dat32;
  logic [1:0]  cs32;
  logic [3:0]  sel32;

  logic        rdy64, rv64, we64, cyc64, stb64;
  logic [63:0] rd64, dat64;
  logic [31:0] adr64;
  logic [1:0]  cs64;
  logic [7:0]  sel64;

  wb_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v32), .req_ready_o(rdy32), .req_we_i(we),
    .req_size_i(size), .req_unsigned_i(uns), .req_addr_i(addr), .req_wdata_i(wdata[31:0]),
    .rsp_valid_o(rv32), .rsp_rdata_o(rd32), .rsp_cause_o(cs32), .wb_adr_o(adr32),
    .wb_dat_o(dat32), .wb_sel_o(sel32), .wb_we_o(we32), .wb_cyc_o(cyc32), .wb_stb_o(stb32),
    .wb_dat_i(bdat[31:0]), .wb_ack_i(ack32), .wb_err_i(err32)
  );

  wb_lsu #(.DW(64), .AW(32), .TIMEOUT(255)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v64), .req_ready_o(rdy64), .req_we_i(we),
    .req_size_i(size), .req_unsigned_i(uns), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rv64), .rsp_rdata_o(rd64), .rsp_cause_o(cs64), .wb_adr_o(adr64),
    .wb_dat_o(dat64), .wb_sel_o(sel64), .wb_we_o(we64), .wb_cyc_o(cyc64), .wb_stb_o(stb64),
    .wb_dat_i(bdat), .wb_ack_i(ack64), .wb_err_i(err64)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge (cycle N+1).
  task automatic issue(input bit is64, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [63:0] wd);
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    if (is64) v64 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    // Scramble request fields: they must have been latched.
    size = 2'd3; uns = ~u; addr = 32'hFFFF_FFFF; wdata = '1;
  endtask

  // Aligned access with a zero-wait ack.
  task automatic txn(input string tag, input bit is64, input bit w, input logic [1:0] sz,
                     input bit u, input logic [31:0] a, input logic [63:0] wd,
                     input logic [63:0] bd, input logic [31:0] e_adr, input logic [7:0] e_sel,
                     input logic [63:0] e_dat, input logic [63:0] e_rd);
    issue(is64, w, sz, u, a, wd);
    bdat = bd;
    if (is64) ack64 = 1'b1; else ack32 = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_cyc", tag), is64 ? {cyc64, stb64} : {cyc32, stb32}, 2'b11);
    chk($sformatf("%s_adr", tag), is64 ? adr64 : adr32, e_adr);
    chk($sformatf("%s_sel", tag), is64 ? sel64 : {4'h0, sel32}, e_sel);
    chk($sformatf("%s_we", tag), is64 ? we64 : we32, w);
    if (w) chk($sformatf("%s_dat", tag), is64 ? dat64 : {32'h0, dat32}, e_dat);
    chk($sformatf("%s_rv_early", tag), is64 ? rv64 : rv32, 1'b0);
    @(posedge clk); #1;
    ack32 = 1'b0; ack64 = 1'b0; bdat = '0;
    @(negedge clk);
    chk($sformatf("%s_rv", tag), is64 ? rv64 : rv32, 1'b1);
    chk($sformatf("%s_rdata", tag), is64 ? rd64 : {32'h0, rd32}, e_rd);
    chk($sformatf("%s_cause", tag), is64 ? cs64 : cs32, 2'd0);
    chk($sformatf("%s_cyc_off", tag), is64 ? cyc64 : cyc32, 1'b0);
    @(posedge clk); #1;
    chk($sformatf("%s_rv_once", tag), is64 ? rv64 : rv32, 1'b0);
    chk($sformatf("%s_ready", tag), is64 ? rdy64 : rdy32, 1'b1);
  endtask

  task automatic misal(input string tag, input bit is64, input logic [1:0] sz,
                       input logic [31:0] a);
    issue(is64, 1'b0, sz, 1'b0, a, 64'h0);
    @(negedge clk);
    chk($sformatf("%s_rv", tag), is64 ? rv64 : rv32, 1'b1);
    chk($sformatf("%s_cause", tag), is64 ? cs64 : cs32, 2'd1);
    chk($sformatf("%s_cyc", tag), is64 ? cyc64 : cyc32, 1'b0);
    chk($sformatf("%s_rdata", tag), is64 ? rd64 : {32'h0, rd32}, 64'h0);
    @(posedge clk); #1;
    chk($sformatf("%s_done", tag), is64 ? {rv64, cyc64, rdy64} : {rv32, cyc32, rdy32}, 3'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          hi;
    int          rvs;
    bit          got_rsp;
    logic [1:0]  c;

    rst = 1'b1; v32 = 1'b0; v64 = 1'b0; we = 1'b0; uns = 1'b0; size = '0; addr = '0;
    wdata = '0; bdat = '0; ack32 = 1'b0; err32 = 1'b0; ack64 = 1'b0; err64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {rdy32, rdy64}, 2'b11);
    chk("rst_cyc", {cyc32, stb32, cyc64, stb64}, 4'h0);
    chk("rst_rv", {rv32, rv64}, 2'b00);
    chk("rst_sel_adr", {sel32, sel64, adr32, adr64}, 76'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loads and stores, 32-bit bus.
    txn("ldb_s", 0, 0, 2'd0, 0, 32'h103, 64'h0, 64'h80AABBCC, 32'h100, 8'h08, 64'h0,
        64'hFFFFFF80);
    txn("ldh_u", 0, 0, 2'd1, 1, 32'h102, 64'h0, 64'h80AABBCC, 32'h100, 8'h0C, 64'h0,
        64'h000080AA);
    txn("ldb_u", 0, 0, 2'd0, 1, 32'h101, 64'h0, 64'h80AABBCC, 32'h100, 8'h02, 64'h0,
        64'h000000BB);
    txn("ldh_s", 0, 0, 2'd1, 0, 32'h100, 64'h0, 64'h1234F00D, 32'h100, 8'h03, 64'h0,
        64'hFFFFF00D);
    txn("stw", 0, 1, 2'd2, 0, 32'h204, 64'hDEADBEEF, 64'h0, 32'h204, 8'h0F, 64'hDEADBEEF,
        64'h0);
    txn("stb", 0, 1, 2'd0, 0, 32'h202, 64'h5A, 64'hFFFFFFFF, 32'h200, 8'h04, 64'h005A0000,
        64'h0);

    // 64-bit bus.
    txn("st64h", 1, 1, 2'd1, 0, 32'h06, 64'h1234, 64'h0, 32'h0, 8'hC0, 64'h1234000000000000,
        64'h0);
    txn("ld64w", 1, 0, 2'd2, 0, 32'h0C, 64'h0, 64'h8765432100000000, 32'h8, 8'hF0, 64'h0,
        64'hFFFFFFFF87654321);
    txn("ld64d", 1, 0, 2'd3, 0, 32'h10, 64'h0, 64'h0123456789ABCDEF, 32'h10, 8'hFF, 64'h0,
        64'h0123456789ABCDEF);

    // Misaligned requests never touch the bus.
    misal("mis_w", 0, 2'd2, 32'h102);
    misal("mis_d32", 0, 2'd3, 32'h0);
    misal("mis_h64", 1, 2'd1, 32'h7);

    // Timeout: cyc held for exactly TIMEOUT cycles, then cause 3.
    issue(0, 0, 2'd2, 0, 32'h10, 64'h0);
    hi = 0; got_rsp = 1'b0; c = 2'd0;
    for (int i = 0; i < 10 && !got_rsp; i++) begin
      @(negedge clk);
      if (cyc32) hi++;
      if (rv32) begin
        got_rsp = 1'b1;
        c = cs32;
      end
    end
    chk("to_cyc_cycles", 64'(hi), 64'd4);
    chk("to_rsp", got_rsp, 1'b1);
    chk("to_cause", c, 2'd3);
    @(posedge clk); #1;

    // Ack on the last allowed cycle wins over the timeout.
    issue(0, 0, 2'd2, 0, 32'h14, 64'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    ack32 = 1'b1; bdat = 64'h11223344;
    @(posedge clk); #1;
    ack32 = 1'b0; bdat = '0;
    @(negedge clk);
    chk("late_ack_rv", rv32, 1'b1);
    chk("late_ack_cause", cs32, 2'd0);
    chk("late_ack_rdata", rd32, 32'h11223344);
    @(posedge clk); #1;

    // err and ack together: error wins.
    issue(0, 0, 2'd2, 0, 32'h18, 64'h0);
    ack32 = 1'b1; err32 = 1'b1; bdat = 64'hCAFEF00D;
    @(posedge clk); #1;
    ack32 = 1'b0; err32 = 1'b0; bdat = '0;
    @(negedge clk);
    chk("err_rv", rv32, 1'b1);
    chk("err_cause", cs32, 2'd2);
    chk("err_rdata", rd32, 32'h0);
    @(posedge clk); #1;

    // Reset in the middle of a bus cycle.
    issue(0, 0, 2'd2, 0, 32'h1C, 64'h0);
    @(negedge clk);
    chk("rstbus_cyc_pre", cyc32, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstbus_cyc", {cyc32, stb32}, 2'b00);
    chk("rstbus_ready", rdy32, 1'b1);
    chk("rstbus_rv", rv32, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ack32 = 1'b1; bdat = 64'h55555555;
    @(posedge clk); #1;
    ack32 = 1'b0; bdat = '0;
    rvs = 0;
    repeat (3) begin
      @(negedge clk);
      rvs += int'(rv32) + int'(cyc32);
    end
    chk("rstbus_no_rsp", 64'(rvs), 64'd0);
    @(posedge clk); #1;
    txn("post_rst", 0, 0, 2'd0, 0, 32'h3, 64'h0, 64'h7F000000, 32'h0, 8'h08, 64'h0,
        64'h7F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_lsu.md
WB_LSU -- requirements
Module: wb_lsu

Interface
REQ-001 SHALL have parameter DW, default 32, data bus width in bits (legal: 32, 64).
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for ack/err (0 = timeout disabled).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  clock; all state on rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 req_valid_i  in  1  core request valid.
REQ-008 req_ready_o  out  1  unit can accept a request.
REQ-009 req_we_i  in  1  1 = store, 0 = load.
REQ-010 req_size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 req_unsigned_i  in  1  zero-extend load (else sign-extend).
REQ-012 req_addr_i  in  AW  byte address.
REQ-013 req_wdata_i  in  DW  store data, right-justified.
REQ-014 rsp_valid_o  out  1  one-cycle response strobe.
REQ-015 rsp_rdata_o  out  DW  extended load data; 0 for stores and errors.
REQ-016 rsp_cause_o  out  2  0 ok, 1 misaligned, 2 bus error, 3 timeout.
REQ-017 wb_adr_o  out  AW  bus address, aligned to DW/8.
REQ-018 wb_dat_o  out  DW  lane-steered write data.
REQ-019 wb_sel_o  out  DW/8  byte-lane enables.
REQ-020 wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone classic controls.
REQ-021 wb_dat_i  in  DW; wb_ack_i  in  1; wb_err_i  in  1  Wishbone returns.

Function
REQ-022 SHALL allow one outstanding transaction; states IDLE, BUS, RESP.
REQ-023 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-024 Misaligned request (addr mod 2^size != 0, or size 3 with DW=32) SHALL skip BUS: RESP next cycle, cause 1, no bus cycle.
REQ-025 Aligned request SHALL enter BUS; cyc/stb/we/adr/sel/dat registered and asserted the cycle after acceptance.
REQ-026 wb_sel_o SHALL be (2^(2^size)-1) shifted left by offset = addr mod DW/8; wb_dat_o = wdata shifted left by 8*offset.
REQ-027 In BUS, wb_err_i SHALL take priority over wb_ack_i; err -> cause 2, ack -> cause 0 and capture wb_dat_i; either drops cyc/stb next edge and enters RESP.
REQ-028 A cycle counter SHALL start at 0 on BUS entry; when it reaches TIMEOUT (TIMEOUT>0) without ack/err, cyc/stb drop and RESP with cause 3.
REQ-029 RESP SHALL assert rsp_valid_o for exactly one cycle, then return to IDLE.
REQ-030 Load data SHALL be wb_dat_i shifted right by 8*offset, truncated to size, then zero/sign-extended to DW.
REQ-031 Latency: accept at cycle N, zero-wait ack at N+1 -> rsp_valid_o at N+2; misaligned -> N+1.
REQ-032 Inputs other than wb_* SHALL be ignored outside IDLE; request fields are latched at acceptance.

Reset
REQ-033 Asserting rst_i SHALL immediately force state IDLE, counter 0, all outputs 0 except req_ready_o=1.
REQ-034 Reset mid-BUS SHALL drop cyc/stb without producing a response; a late ack after reset SHALL be ignored.

Structure
REQ-035 Package lsu_pkg SHALL hold size encodings, cause encodings and the state enumeration.
REQ-036 Lane steering and extension SHALL be one combinational sub-module lsu_lane_align; FSM, counter and bus registers stay in wb_lsu.

Verification
REQ-037 DW=32 load byte signed, addr 0x103, wb_dat_i 0x80AABBCC, ack at N+1 -> sel 0x8, adr 0x100, rsp_rdata 0xFFFFFF80, cause 0 at N+2.
REQ-038 DW=64 store half, addr 0x06, wdata 0x1234 -> sel 0xC0, wb_dat_o 0x1234000000000000, we=1; ack -> rsp cause 0, rdata 0.
REQ-039 Load word addr 0x102 -> no cyc ever, rsp_valid at N+1, cause 1.
REQ-040 TIMEOUT=4, no ack -> cyc dropped after 4 BUS cycles, cause 3; ack and err in same cycle -> cause 2.
REQ-041 rst_i asserted during BUS -> cyc/stb 0 combinationally, no rsp_valid, req_ready_o=1; next request completes normally.
